ntt_ctrl: RTL
=============

// Module: ntt_ctrl
// PURPOSE
//  Sequencer for the single-cycle butterfly: runs one full in-place NTT (CT) or INTT (GS) over an
//  N-coefficient dual-port RAM. Generates read/write pair addresses, twiddle-ROM index and the
//  butterfly mode/reduction selects. Sits between the top-level command interface and the RAM/ROM.
// PARAMETERS
//  N        256  coefficients per polynomial (power of 2)
//  LOG2N    8    log2(N)
//  MEM_LAT  1    RAM read latency in cycles (>=1); butterfly is combinational after RAM output
// PORTS
//  clk_i            in   1      clock
//  rst_i            in   1      synchronous reset, active-high
//  start_i          in   1      start request, sampled only in IDLE
//  mode_i           in   1      0 = NTT (Cooley-Tukey), 1 = INTT (Gentleman-Sande); latched at start
//  sel_red_i        in   1      0 = q 8380417 (8 layers), 1 = q 3329 (7 layers, stop at len 2); latched
//  busy_o           out  1      operation in progress
//  done_o           out  1      one-cycle completion pulse
//  rd_en_o          out  1      RAM read strobe for the pair
//  rd_addr_a_o      out  LOG2N  read address of coefficient a
//  rd_addr_b_o      out  LOG2N  read address of coefficient b (= a + len)
//  tw_addr_o        out  LOG2N  twiddle ROM index, aligned with RAM data (delayed MEM_LAT)
//  tw_inv_o         out  1      selects inverse-twiddle table (= latched mode)
//  wr_en_o          out  1      RAM write strobe for butterfly results
//  wr_addr_a_o      out  LOG2N  write address for a_out
//  wr_addr_b_o      out  LOG2N  write address for b_out
//  sel_butterfly_o  out  1      to butterfly (= latched mode)
//  sel_red_o        out  1      to butterfly (= latched sel_red)
//  cycles_o         out  16     busy-cycle count (see CONFIGURATION)
// BEHAVIOUR
//  - Reset: FSM=IDLE; every output 0; counters and delay line cleared; no RAM write after reset edge.
//  - FSM: IDLE -start_i-> RUN; RUN -last pair of stage issued-> DRAIN; DRAIN (MEM_LAT cycles) ->
//    RUN if more stages, else DONE; DONE -> IDLE (1 cycle). start_i outside IDLE is ignored.
//  - Stages: NTT len = N/2,N/4,..,1 (Kyber ..,2); INTT len = 1 (Kyber 2),..,N/2.
//  - Per stage, issue one pair per RUN cycle, j innermost, group g outer:
//    a = g*2*len + j, b = a + len, j in [0,len), g in [0,N/(2len)); tw index = N/(2len) + g.
//  - Write path: {rd_addr_a, rd_addr_b, rd_en, tw index} delayed MEM_LAT cycles -> wr_addr_*, wr_en_o;
//    tw_addr_o leaves same delay so twiddle meets RAM data. Pair read at cycle c written at c+MEM_LAT.
//  - DRAIN: rd_en_o=0; ensures last write of stage s lands before first read of stage s+1 (no RAW hazard).
//  - Timing: start sampled at edge t0; busy_o=1 from t0+1 through last DRAIN cycle; each stage takes
//    N/2 + MEM_LAT cycles; done_o=1 and busy_o=0 in DONE cycle.
//    N=256,MEM_LAT=1: 8 stages -> 1032 busy cycles; Kyber 7 stages -> 903.
//  - Mode/sel_red changes during busy have no effect; latched values hold until next start.
//  - rst_i mid-operation: abort immediately to IDLE, wr_en_o=0 next cycle, no done_o pulse.
//  - start_i high in DONE cycle is ignored; held high afterwards it restarts from IDLE next cycle.
// CONFIGURATION
//  - NTT_CTRL_PERF_EN defined: cycles_o cleared at start, increments each busy cycle, saturates at
//    16'hFFFF, holds after done until next start; reset -> 0.
//  - Not defined: cycles_o tied to 16'd0, no counter logic.
// STRUCTURE
//  - ntt_pkg: typedef enum {IDLE,RUN,DRAIN,DONE} ntt_state_e; constants Q_DILITHIUM=8380417,
//    Q_KYBER=3329, N/LOG2N defaults, layer counts (8/7).
//  - One sub-module: ntt_addr_gen (len/j/g counters, produces a,b,tw index, last_pair/last_stage flags);
//    ntt_ctrl holds FSM, latch registers, MEM_LAT delay line and perf counter.
// TESTING
//  1. Reset, start_i=1 mode=0 sel_red=0 -> first pairs (0,128,tw1),(1,129,tw1); done after 1032 busy cycles.
//  2. mode=1 sel_red=1 -> first stage pairs (0,2),(1,3),(4,6) tw 64,64,65; 7 stages, 903 busy cycles.
//  3. Stage boundary N=256 NTT: last pair stage0 (127,255) write lands one cycle before read (0,64) of
//     stage1; rd_en_o=0 during DRAIN cycle.
//  4. rst_i asserted at busy cycle 500 -> all outputs 0 next cycle, no done_o; restart completes normally.
//  5. start_i toggled and mode_i flipped while busy -> ignored; sel_butterfly_o constant whole run.
//  6. NTT_CTRL_PERF_EN: Dilithium NTT -> cycles_o=1032 held after done; without macro cycles_o=0.

Source files
------------

// File: rtl/ntt_pkg.sv
// ntt_pkg: shared state encoding, moduli and size defaults for the NTT sequencer
package ntt_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} ntt_state_e;
  localparam int unsigned Q_DILITHIUM = 8380417;
  localparam int unsigned Q_KYBER = 3329;
  localparam int N_DEF = 256;
  localparam int LOG2N_DEF = 8;
  localparam int LAYERS_DILITHIUM = 8;
  localparam int LAYERS_KYBER = 7;
endpackage

// File: rtl/ntt_addr_gen.sv
// ntt_addr_gen: pair/stage counters producing butterfly addresses and twiddle index
module ntt_addr_gen
  import ntt_pkg::*;
#(
  parameter int N = N_DEF,
  parameter int LOG2N = LOG2N_DEF,
  localparam int SW = $clog2(LOG2N)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             init_i,
  input  logic             adv_i,
  input  logic             next_stage_i,
  input  logic             mode_i,
  input  logic             sel_red_i,
  output logic [LOG2N-1:0] a_o,
  output logic [LOG2N-1:0] b_o,
  output logic [LOG2N-1:0] tw_o,
  output logic             last_pair_o,
  output logic             last_stage_o
);
  logic [LOG2N-2:0] p;
  logic [SW-1:0] sh, sh_first, sh_last;
  logic [LOG2N-1:0] pw, len, j, g;
  // len = 1 << sh; the pair counter p splits into group (upper) and j (lower sh bits)
  always_comb begin
    sh_first = mode_i ? SW'(sel_red_i) : SW'(LOG2N-1);
    sh_last = mode_i ? SW'(LOG2N-1) : SW'(sel_red_i);
    pw = {1'b0, p};
    len = LOG2N'(1) << sh;
    j = pw & (len - LOG2N'(1));
    g = pw >> sh;
    a_o = (g << sh << 1) | j;
    b_o = a_o | len;
    tw_o = (LOG2N'(N/2) >> sh) + g;
    last_pair_o = &p;
    last_stage_o = sh == sh_last;
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      p <= '0;
      sh <= '0;
    end else if (init_i) begin
      p <= '0;
      sh <= sh_first;
    end else if (adv_i) begin
      p <= p + (LOG2N-1)'(1);
    end else if (next_stage_i) begin
      sh <= mode_i ? sh + SW'(1) : sh - SW'(1);
    end
  end
endmodule

// File: rtl/ntt_ctrl.sv
// ntt_ctrl: NTT/INTT sequencer with FSM, RAM-latency write delay line and optional
// busy-cycle counter enabled by NTT_CTRL_PERF_EN
module ntt_ctrl
  import ntt_pkg::*;
#(
  parameter int N = N_DEF,
  parameter int LOG2N = LOG2N_DEF,
  parameter int MEM_LAT = 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic             mode_i,
  input  logic             sel_red_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             rd_en_o,
  output logic [LOG2N-1:0] rd_addr_a_o,
  output logic [LOG2N-1:0] rd_addr_b_o,
  output logic [LOG2N-1:0] tw_addr_o,
  output logic             tw_inv_o,
  output logic             wr_en_o,
  output logic [LOG2N-1:0] wr_addr_a_o,
  output logic [LOG2N-1:0] wr_addr_b_o,
  output logic             sel_butterfly_o,
  output logic             sel_red_o,
  output logic [15:0]      cycles_o
);
  localparam logic [1:0] S_IDLE = 2'(IDLE);
  localparam logic [1:0] S_RUN = 2'(RUN);
  localparam logic [1:0] S_DRAIN = 2'(DRAIN);
  localparam logic [1:0] S_DONE = 2'(DONE);
  localparam int DW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam int EW = 3*LOG2N + 1;
  logic [1:0] state, state_nx;
  logic mode_q, red_q, mode_mux, red_mux;
  logic start_ok, run, drain_end, last_pair, last_stage;
  logic [DW-1:0] dcnt;
  logic [LOG2N-1:0] a, b, tw, rd_tw;
  logic [EW-1:0] dl [MEM_LAT];
  assign start_ok = state == S_IDLE && start_i;
  assign run = state == S_RUN;
  assign drain_end = state == S_DRAIN && dcnt == DW'(MEM_LAT-1);
  // in IDLE the address generator must see the incoming mode to pick its first stage
  assign mode_mux = state == S_IDLE ? mode_i : mode_q;
  assign red_mux = state == S_IDLE ? sel_red_i : red_q;
  ntt_addr_gen #(.N(N), .LOG2N(LOG2N)) u_addr_gen (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .init_i      (start_ok),
    .adv_i       (run),
    .next_stage_i(drain_end && !last_stage),
    .mode_i      (mode_mux),
    .sel_red_i   (red_mux),
    .a_o         (a),
    .b_o         (b),
    .tw_o        (tw),
    .last_pair_o (last_pair),
    .last_stage_o(last_stage)
  );
  always_comb begin
    state_nx = start_ok ? S_RUN
             : run ? (last_pair ? S_DRAIN : S_RUN)
             : state == S_DRAIN ? (drain_end ? (last_stage ? S_DONE : S_RUN) : S_DRAIN)
             : S_IDLE;
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= S_IDLE;
      mode_q <= 1'b0;
      red_q <= 1'b0;
      dcnt <= '0;
    end else begin
      state <= state_nx;
      dcnt <= state == S_DRAIN ? dcnt + DW'(1) : '0;
      if (start_ok) begin
        mode_q <= mode_i;
        red_q <= sel_red_i;
      end
    end
  end
  assign busy_o = run || state == S_DRAIN;
  assign done_o = state == S_DONE;
  assign rd_en_o = run;
  assign rd_addr_a_o = run ? a : '0;
  assign rd_addr_b_o = run ? b : '0;
  assign rd_tw = run ? tw : '0;
  assign tw_inv_o = mode_q;
  assign sel_butterfly_o = mode_q;
  assign sel_red_o = red_q;
  // write strobe/addresses and twiddle index trail the read by exactly MEM_LAT cycles
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < MEM_LAT; i++) dl[i] <= '0;
    end else begin
      dl[0] <= {run, rd_addr_a_o, rd_addr_b_o, rd_tw};
      for (int i = 1; i < MEM_LAT; i++) dl[i] <= dl[i-1];
    end
  end
  assign {wr_en_o, wr_addr_a_o, wr_addr_b_o, tw_addr_o} = dl[MEM_LAT-1];
`ifdef NTT_CTRL_PERF_EN
  logic [15:0] cyc_q;
  always_ff @(posedge clk_i) begin
    if (rst_i || start_ok) cyc_q <= '0;
    else if (busy_o && !(&cyc_q)) cyc_q <= cyc_q + 16'd1;
  end
  assign cycles_o = cyc_q;
`else
  assign cycles_o = 16'd0;
`endif
endmodule
